// File: rtl/boid_update_engine.sv
// -----------------------------------------------------------------------------
// boid_update_engine
//   Per-boid state update: margin steering, iterative speed limiting, then
//   position integration. One boid at a time, valid/ready on both sides.
//
//   State | meaning
//   IDLE  | waiting for a boid, in_ready high
//   EDGE  | apply turn nudges for any violated screen margin
//   SPEED | scale velocity by 1 -/+ 2^-SHIFT per cycle until in range
//   MOVE  | integrate position, load output registers
//   DONE  | out_valid high, outputs held until out_ready
//
// Ports
//   clk, reset (async, active low)
//   in_valid/in_ready,  x_in, y_in, vx_in, vy_in       : incoming boid
//   out_valid/out_ready, x_out, y_out, vx_out, vy_out  : updated boid
//   px_out, py_out                                     : previous position
//   iter_count                                         : speed iterations k
// -----------------------------------------------------------------------------
module boid_update_engine #(
  parameter int WIDTH     = 32,
  parameter int FRAC      = 15,
  parameter int LEFT      = 100,
  parameter int RIGHT     = 540,
  parameter int TOP       = 100,
  parameter int BOTTOM    = 380,
  parameter int TURN      = 6554,
  parameter int MAX_SPEED = 196608,
  parameter int MIN_SPEED = 98304,
  parameter int SHIFT     = 3,
  parameter int MAX_ITER  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] vx_in,
  input  logic signed [WIDTH-1:0] vy_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x_out,
  output logic signed [WIDTH-1:0] y_out,
  output logic signed [WIDTH-1:0] vx_out,
  output logic signed [WIDTH-1:0] vy_out,
  output logic signed [WIDTH-1:0] px_out,
  output logic signed [WIDTH-1:0] py_out,
  output logic [4:0]              iter_count
);

  // Margins are given in whole pixels and scaled to fixed point here.
  localparam logic signed [WIDTH-1:0] C_LEFT   = WIDTH'(LEFT   * (2**FRAC));
  localparam logic signed [WIDTH-1:0] C_RIGHT  = WIDTH'(RIGHT  * (2**FRAC));
  localparam logic signed [WIDTH-1:0] C_TOP    = WIDTH'(TOP    * (2**FRAC));
  localparam logic signed [WIDTH-1:0] C_BOTTOM = WIDTH'(BOTTOM * (2**FRAC));
  localparam logic signed [WIDTH-1:0] C_TURN   = WIDTH'(TURN);
  localparam logic [WIDTH:0]          C_MAX_SP = (WIDTH+1)'(MAX_SPEED);
  localparam logic [WIDTH:0]          C_MIN_SP = (WIDTH+1)'(MIN_SPEED);
  localparam logic [4:0]              C_ITER   = 5'(MAX_ITER);
  localparam logic signed [WIDTH-1:0] C_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]        C_MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, EDGE, SPEED, MOVE, DONE} state_t;

  state_t r_state, w_state_nxt;

  logic signed [WIDTH-1:0] r_x, r_y, r_vx, r_vy;
  logic [4:0]              r_k;

  logic signed [WIDTH-1:0] r_x_o, r_y_o, r_vx_o, r_vy_o, r_px_o, r_py_o;
  logic [4:0]              r_k_o;

  logic signed [WIDTH-1:0] w_vx_edge, w_vy_edge;
  logic [WIDTH-1:0]        w_abs_vx, w_abs_vy, w_max, w_min;
  logic [WIDTH:0]          w_s;
  logic                    w_shrink, w_grow;

  // Margin nudges; x and y axes are independent.
  always_comb begin
    w_vx_edge = r_vx;
    w_vy_edge = r_vy;
    if (r_x < C_LEFT)        w_vx_edge = r_vx + C_TURN;
    else if (r_x > C_RIGHT)  w_vx_edge = r_vx - C_TURN;
    if (r_y < C_TOP)         w_vy_edge = r_vy + C_TURN;
    else if (r_y > C_BOTTOM) w_vy_edge = r_vy - C_TURN;
  end

  // Alpha-max/beta-min speed estimate. The most negative word has no
  // positive counterpart, so its magnitude saturates.
  always_comb begin
    w_abs_vx = $unsigned(r_vx);
    w_abs_vy = $unsigned(r_vy);
    if (r_vx == C_MOST_NEG)  w_abs_vx = C_MAX_POS;
    else if (r_vx[WIDTH-1])  w_abs_vx = $unsigned(-r_vx);
    if (r_vy == C_MOST_NEG)  w_abs_vy = C_MAX_POS;
    else if (r_vy[WIDTH-1])  w_abs_vy = $unsigned(-r_vy);
    if (w_abs_vx >= w_abs_vy) begin
      w_max = w_abs_vx;
      w_min = w_abs_vy;
    end else begin
      w_max = w_abs_vy;
      w_min = w_abs_vx;
    end
    w_s      = {1'b0, w_max} + {2'b00, w_min[WIDTH-1:1]};
    w_shrink = (w_s > C_MAX_SP) && (r_k < C_ITER);
    // A stationary boid has no direction to grow along.
    w_grow   = !w_shrink && (w_s < C_MIN_SP) && (w_s != '0) && (r_k < C_ITER);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = EDGE;
      EDGE:    w_state_nxt = SPEED;
      SPEED:   if (!(w_shrink || w_grow)) w_state_nxt = MOVE;
      MOVE:    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_vx   <= '0;
      r_vy   <= '0;
      r_k    <= '0;
      r_x_o  <= '0;
      r_y_o  <= '0;
      r_vx_o <= '0;
      r_vy_o <= '0;
      r_px_o <= '0;
      r_py_o <= '0;
      r_k_o  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x  <= x_in;
            r_y  <= y_in;
            r_vx <= vx_in;
            r_vy <= vy_in;
            r_k  <= '0;
          end
        end
        EDGE: begin
          r_vx <= w_vx_edge;
          r_vy <= w_vy_edge;
        end
        SPEED: begin
          if (w_shrink) begin
            r_vx <= r_vx - (r_vx >>> SHIFT);
            r_vy <= r_vy - (r_vy >>> SHIFT);
            r_k  <= r_k + 5'd1;
          end else if (w_grow) begin
            r_vx <= r_vx + (r_vx >>> SHIFT);
            r_vy <= r_vy + (r_vy >>> SHIFT);
            r_k  <= r_k + 5'd1;
          end
        end
        MOVE: begin
          // Output registers load only here, so they stay frozen while the
          // next boid is being worked on.
          r_px_o <= r_x;
          r_py_o <= r_y;
          r_x_o  <= r_x + r_vx;
          r_y_o  <= r_y + r_vy;
          r_vx_o <= r_vx;
          r_vy_o <= r_vy;
          r_k_o  <= r_k;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign x_out      = r_x_o;
  assign y_out      = r_y_o;
  assign vx_out     = r_vx_o;
  assign vy_out     = r_vy_o;
  assign px_out     = r_px_o;
  assign py_out     = r_py_o;
  assign iter_count = r_k_o;

endmodule

// File: tb/tb_boid_update_engine.sv
// -----------------------------------------------------------------------------
// tb_boid_update_engine
//   Directed scenarios against boid_update_engine with hand-computed results
//   (fix15: 1.0 = 32768, centre of screen x=320.0, y=240.0).
// -----------------------------------------------------------------------------
module tb_boid_update_engine;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] x_in, y_in, vx_in, vy_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] x_out, y_out, vx_out, vy_out, px_out, py_out;
  logic [4:0]         iter_count;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic signed [31:0] XC = 32'sd10485760;  // 320.0
  localparam logic signed [31:0] YC = 32'sd7864320;   // 240.0

  boid_update_engine dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x_in       (x_in),
    .y_in       (y_in),
    .vx_in      (vx_in),
    .vy_in      (vy_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .x_out      (x_out),
    .y_out      (y_out),
    .vx_out     (vx_out),
    .vy_out     (vy_out),
    .px_out     (px_out),
    .py_out     (py_out),
    .iter_count (iter_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits for in_ready, presents one boid, then counts edges after the
  // accepting edge until out_valid is seen (capped at 40).
  task automatic send_and_wait(input logic signed [31:0] x, y, vx, vy,
                               output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1; x_in = x; y_in = y; vx_in = vx; vy_in = vy;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    x_in = XC; y_in = YC; vx_in = 32'sd131072; vy_in = 32'sd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    n_cmp++; if (iter_count !== 5'd0) begin n_err++; $display("FAIL rst_iter: got %0d want 0", iter_count); end
    n_cmp++; if ({x_out, y_out, vx_out, vy_out, px_out, py_out} !== '0) begin n_err++; $display("FAIL rst_data: x=%0d y=%0d vx=%0d vy=%0d px=%0d py=%0d want all 0", x_out, y_out, vx_out, vy_out, px_out, py_out); end
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_no_capture: in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_center();
    int lat;
    send_and_wait(XC, YC, 32'sd131072, 32'sd0, lat);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL center_latency: got %0d want 3", lat); end
    n_cmp++; if (x_out !== 32'sd10616832) begin n_err++; $display("FAIL center_x: got %0d want 10616832", x_out); end
    n_cmp++; if (px_out !== XC) begin n_err++; $display("FAIL center_px: got %0d want %0d", px_out, XC); end
    n_cmp++; if (y_out !== YC || py_out !== YC) begin n_err++; $display("FAIL center_y: got y=%0d py=%0d want %0d", y_out, py_out, YC); end
    n_cmp++; if (vx_out !== 32'sd131072 || vy_out !== 32'sd0) begin n_err++; $display("FAIL center_v: got vx=%0d vy=%0d want 131072 0", vx_out, vy_out); end
    n_cmp++; if (iter_count !== 5'd0) begin n_err++; $display("FAIL center_k: got %0d want 0", iter_count); end
    release_out();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL center_release: got out_valid=%0b in_ready=%0b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_left_margin();
    int lat;
    send_and_wait(32'sd1638400, YC, 32'sd131072, 32'sd0, lat);
    n_cmp++; if (vx_out !== 32'sd137626) begin n_err++; $display("FAIL left_vx: got %0d want 137626", vx_out); end
    n_cmp++; if (x_out !== 32'sd1776026) begin n_err++; $display("FAIL left_x: got %0d want 1776026", x_out); end
    n_cmp++; if (iter_count !== 5'd0 || lat !== 3) begin n_err++; $display("FAIL left_k_lat: got k=%0d lat=%0d want 0 3", iter_count, lat); end
    release_out();
  endtask

  // x beyond RIGHT and y above TOP: both nudges, then one shrink step.
  task automatic test_right_top();
    int lat;
    send_and_wait(32'sd19660800, 32'sd1638400, -32'sd131072, 32'sd131072, lat);
    n_cmp++; if (vx_out !== -32'sd120422 || vy_out !== 32'sd120423) begin n_err++; $display("FAIL rt_v: got vx=%0d vy=%0d want -120422 120423", vx_out, vy_out); end
    n_cmp++; if (x_out !== 32'sd19540378 || y_out !== 32'sd1758823) begin n_err++; $display("FAIL rt_pos: got x=%0d y=%0d want 19540378 1758823", x_out, y_out); end
    n_cmp++; if (iter_count !== 5'd1 || lat !== 4) begin n_err++; $display("FAIL rt_k_lat: got k=%0d lat=%0d want 1 4", iter_count, lat); end
    release_out();
  endtask

  task automatic test_bottom();
    int lat;
    send_and_wait(XC, 32'sd13107200, 32'sd131072, 32'sd0, lat);
    n_cmp++; if (vy_out !== -32'sd6554 || y_out !== 32'sd13100646) begin n_err++; $display("FAIL bottom: got vy=%0d y=%0d want -6554 13100646", vy_out, y_out); end
    n_cmp++; if (x_out !== 32'sd10616832 || iter_count !== 5'd0) begin n_err++; $display("FAIL bottom_x_k: got x=%0d k=%0d want 10616832 0", x_out, iter_count); end
    release_out();
  endtask

  task automatic test_shrink();
    int lat;
    send_and_wait(XC, YC, 32'sd262144, 32'sd0, lat);
    n_cmp++; if (vx_out !== 32'sd175616) begin n_err++; $display("FAIL shrink_vx: got %0d want 175616", vx_out); end
    n_cmp++; if (iter_count !== 5'd3) begin n_err++; $display("FAIL shrink_k: got %0d want 3", iter_count); end
    n_cmp++; if (lat !== 6) begin n_err++; $display("FAIL shrink_latency: got %0d want 6", lat); end
    n_cmp++; if (x_out !== (XC + 32'sd175616)) begin n_err++; $display("FAIL shrink_x: got %0d want %0d", x_out, XC + 32'sd175616); end
    release_out();
  endtask

  task automatic test_grow();
    int lat;
    send_and_wait(XC, YC, -32'sd65536, 32'sd0, lat);
    n_cmp++; if (vx_out !== -32'sd104976) begin n_err++; $display("FAIL grow_vx: got %0d want -104976", vx_out); end
    n_cmp++; if (iter_count !== 5'd4 || lat !== 7) begin n_err++; $display("FAIL grow_k_lat: got k=%0d lat=%0d want 4 7", iter_count, lat); end
    release_out();
  endtask

  // Most-negative vx is far too fast; limiting stops at the iteration bound.
  task automatic test_max_iter();
    int lat;
    send_and_wait(XC, YC, 32'sh8000_0000, 32'sd0, lat);
    n_cmp++; if (iter_count !== 5'd16) begin n_err++; $display("FAIL maxiter_k: got %0d want 16", iter_count); end
    n_cmp++; if (lat !== 19) begin n_err++; $display("FAIL maxiter_latency: got %0d want 19", lat); end
    n_cmp++; if (vy_out !== 32'sd0 || vx_out >= 0) begin n_err++; $display("FAIL maxiter_v: got vx=%0d vy=%0d want vx<0 vy=0", vx_out, vy_out); end
    release_out();
  endtask

  task automatic test_hold();
    int lat;
    send_and_wait(XC, YC, 32'sd0, 32'sd0, lat);
    n_cmp++; if (iter_count !== 5'd0 || lat !== 3) begin n_err++; $display("FAIL zero_k_lat: got k=%0d lat=%0d want 0 3", iter_count, lat); end
    n_cmp++; if (x_out !== XC || px_out !== XC) begin n_err++; $display("FAIL zero_pos: got x=%0d px=%0d want %0d", x_out, px_out, XC); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i % 2 == 0); x_in = 32'sd1; y_in = 32'sd2; vx_in = 32'sd3; vy_in = 32'sd4;
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL hold_handshake[%0d]: got out_valid=%0b in_ready=%0b want 1 0", i, out_valid, in_ready); end
      n_cmp++; if (x_out !== XC || y_out !== YC || vx_out !== 32'sd0) begin n_err++; $display("FAIL hold_stable[%0d]: got x=%0d y=%0d vx=%0d want %0d %0d 0", i, x_out, y_out, vx_out, XC, YC); end
    end
    @(negedge clk); in_valid = 1'b0;
    release_out();
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL hold_ignored: got in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid); end
  endtask

  // out_ready held high throughout: it must not short-cut processing, and
  // the done cycle must not also accept a new boid.
  task automatic test_back_to_back();
    int lat;
    @(negedge clk); out_ready = 1'b1;
    send_and_wait(32'sd1638400, YC, 32'sd131072, 32'sd0, lat);
    n_cmp++; if (lat !== 3 || x_out !== 32'sd1776026) begin n_err++; $display("FAIL b2b_first: got lat=%0d x=%0d want 3 1776026", lat, x_out); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_done_ready: got %0b want 0", in_ready); end
    send_and_wait(XC, YC, 32'sd262144, 32'sd0, lat);
    n_cmp++; if (lat !== 6 || vx_out !== 32'sd175616 || iter_count !== 5'd3) begin n_err++; $display("FAIL b2b_second: got lat=%0d vx=%0d k=%0d want 6 175616 3", lat, vx_out, iter_count); end
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    int lat;
    @(negedge clk);
    in_valid = 1'b1; x_in = XC; y_in = YC; vx_in = 32'sd262144; vy_in = 32'sd0;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_handshake: got out_valid=%0b in_ready=%0b want 0 1", out_valid, in_ready); end
    n_cmp++; if ({x_out, y_out, vx_out, vy_out, px_out, py_out} !== '0 || iter_count !== 5'd0) begin n_err++; $display("FAIL midrst_data: x=%0d vx=%0d px=%0d k=%0d want all 0", x_out, vx_out, px_out, iter_count); end
    @(negedge clk); reset = 1'b1;
    send_and_wait(XC, YC, 32'sd131072, 32'sd0, lat);
    n_cmp++; if (lat !== 3 || x_out !== 32'sd10616832 || px_out !== XC) begin n_err++; $display("FAIL midrst_next: got lat=%0d x=%0d px=%0d want 3 10616832 %0d", lat, x_out, px_out, XC); end
    release_out();
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
    x_in = '0; y_in = '0; vx_in = '0; vy_in = '0;
    #2;
    test_reset();
    test_center();
    test_left_margin();
    test_right_top();
    test_bottom();
    test_shrink();
    test_grow();
    test_max_iter();
    test_hold();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
